// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encoding, control states and
// the classifier that separates single-cycle ops from iterative MUL/DIV ops.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_iterative(alu_op_t op);
    return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply and restoring divide on unsigned
// magnitudes, sharing one 2*WIDTH accumulator. Signs are handled by the caller.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  alu_op_t            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem,
  output logic [2*WIDTH-1:0] prod,
  output logic               done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m_q;
  logic               is_mul_q;
  logic               running;
  logic [CW-1:0]      count;
  logic               start_mul;

  // Multiply: high half accumulates, low half holds the multiplier and is shifted out.
  // Divide: high half is the partial remainder, low half fills with quotient bits.
  function automatic logic [2*WIDTH-1:0] step(logic [2*WIDTH-1:0] cur, logic is_mul,
                                              logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    if (is_mul) begin
      sum = {1'b0, cur[2*WIDTH-1:WIDTH]} + (cur[0] ? {1'b0, m} : '0);
      return {sum, cur[WIDTH-1:1]};
    end
    trial = cur[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    if (!trial[WIDTH]) return {trial[WIDTH-1:0], cur[WIDTH-2:0], 1'b1};
    return {cur[2*WIDTH-2:0], 1'b0};
  endfunction

  assign start_mul = op inside {OP_MUL, OP_MULHU};

  // The first iteration runs on the start edge so the result is ready WIDTH edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      m_q      <= '0;
      is_mul_q <= 1'b0;
      running  <= 1'b0;
      count    <= '0;
    end else if (start) begin
      acc      <= step({{WIDTH{1'b0}}, a}, start_mul, b);
      m_q      <= b;
      is_mul_q <= start_mul;
      running  <= 1'b1;
      count    <= CW'(WIDTH - 1);
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        acc   <= step(acc, is_mul_q, m_q);
        count <= count - CW'(1);
      end
    end
  end

  assign done = running && (count == '0);
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];
  assign prod = acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready request and response ports. Logic ops and
// MUL/DIV special cases finish in one cycle; MUL/DIV otherwise take WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  alu_op_t          op;
  alu_op_t          op_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             signed_div;
  logic             div_zero;
  logic             overflow;
  logic             fast;
  logic             start;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick;
  logic [WIDTH-1:0] fixed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] md_quo;
  logic [WIDTH-1:0] md_rem;
  logic [2*WIDTH-1:0] md_prod;
  logic             md_done;

  assign op         = alu_op_t'(ALUControl);
  assign shamt      = SrcB[SHW-1:0];
  assign signed_div = op inside {OP_DIV, OP_REM};
  assign div_zero   = (SrcB == '0);
  assign overflow   = signed_div && (SrcA == MOST_NEG) && (SrcB == '1);
  assign fast       = !is_iterative(op) || div_zero || overflow;
  assign in_ready   = (state == IDLE) && !rst;
  assign start      = in_ready && in_valid && !fast;
  assign busy       = (state != IDLE);

  assign mag_a = (signed_div && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign mag_b = (signed_div && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  always_comb begin
    quick = '0;
    case (op)
      OP_ADD:   quick = SrcA + SrcB;
      OP_SUB:   quick = SrcA - SrcB;
      OP_AND:   quick = SrcA & SrcB;
      OP_OR:    quick = SrcA | SrcB;
      OP_XOR:   quick = SrcA ^ SrcB;
      OP_SLT:   quick = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU:  quick = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL:   quick = SrcA << shamt;
      OP_SRL:   quick = SrcA >> shamt;
      OP_SRA:   quick = $signed(SrcA) >>> shamt;
      // Only the divide-by-zero and overflow shortcuts reach here for DIV/REM.
      OP_DIV:   quick = div_zero ? '1 : SrcA;
      OP_DIVU:  quick = '1;
      OP_REM:   quick = div_zero ? SrcA : '0;
      OP_REMU:  quick = SrcA;
      default:  quick = '0;
    endcase
  end

  always_comb begin
    fixed = md_quo;
    case (op_q)
      OP_MUL:   fixed = md_prod[WIDTH-1:0];
      OP_MULHU: fixed = md_prod[2*WIDTH-1:WIDTH];
      OP_DIV:   fixed = q_neg_q ? -md_quo : md_quo;
      OP_REM:   fixed = r_neg_q ? -md_rem : md_rem;
      OP_REMU:  fixed = md_rem;
      default:  fixed = md_quo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      op_q      <= OP_ADD;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            q_neg_q <= signed_div && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            r_neg_q <= signed_div && SrcA[WIDTH-1];
            if (fast) begin
              ALUResult <= quick;
              Zero      <= (quick == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            ALUResult <= fixed;
            Zero      <= (fixed == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (mag_a),
    .b    (mag_b),
    .quo  (md_quo),
    .rem  (md_rem),
    .prod (md_prod),
    .done (md_done)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a transaction-level model predicts result and
// latency of every accepted request; a per-cycle monitor compares the DUT to it.
module tb_alu_seq;

  localparam int W = 32;
  localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUControl;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint     sa;
    longint     sb;
    longint     q;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {32'b0, a} * {32'b0, b};
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return $signed(a) >>> sh;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: begin
        if (b == 0) return '1;
        q = sa / sb;
        return q[31:0];
      end
      4'd13: return (b == 0) ? '1 : a / b;
      4'd14: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (op < 4'd10) return 1;
    if (b == 0) return 1;
    if ((op == 4'd12 || op == 4'd14) && a == MOST_NEG && b == '1) return 1;
    return W + 1;
  endfunction

  // Transaction model: one outstanding request, result visible from edge 'due'.
  int unsigned  ncyc    = 0;
  bit           started = 1'b0;
  bit           pending = 1'b0;
  int unsigned  due     = 0;
  logic [W-1:0] exp_res = '0;

  always @(posedge clk) begin
    ncyc++;
    started = 1'b1;
    if (rst) begin
      pending = 1'b0;
    end else if (pending) begin
      if (ncyc > due && out_ready) pending = 1'b0;
    end else if (in_valid) begin
      pending = 1'b1;
      exp_res = model_res(ALUControl, SrcA, SrcB);
      due     = ncyc + model_lat(ALUControl, SrcA, SrcB) - 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic exp_v;
      exp_v = pending && (ncyc >= due);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      check("in_ready", {31'b0, in_ready}, {31'b0, (!pending && !rst)});
      check("busy", {31'b0, busy}, {31'b0, pending});
      if (exp_v) begin
        check("ALUResult", ALUResult, exp_res);
        check("Zero", {31'b0, Zero}, {31'b0, (exp_res == 0)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for the result, stall the consumer 'hold' cycles with junk requests, then consume.
  task automatic finish_op(input int hold);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < W + 10) begin
      tick();
      n++;
    end
    check("result_timeout", {31'b0, out_valid}, 32'd1);
    repeat (hold) begin
      in_valid   = 1'b1;
      ALUControl = 4'($urandom);
      SrcA       = $urandom;
      SrcB       = $urandom;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MOST_NEG;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           hold;
  } vec_t;

  vec_t vecs[14] = '{
    '{4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 0},
    '{4'd5,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 0},
    '{4'd6,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 0},
    '{4'd9,  32'h8000_0000, 32'd36,        32'hF800_0000, 0},
    '{4'd10, 32'h1234_5678, 32'h10,        32'h2345_6780, 0},
    '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0},
    '{4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5},
    '{4'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0},
    '{4'd13, 32'd100,       32'd7,         32'd14,        0},
    '{4'd15, 32'd100,       32'd7,         32'd2,         0},
    '{4'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, 0},
    '{4'd14, 32'd5,         32'd0,         32'd5,         0},
    '{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
    '{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0}
  };

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    ALUControl = 4'd0;
    SrcA       = 32'd1;
    SrcB       = 32'd2;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();

    // Hand-computed values pin the model, then the same requests go through the DUT.
    foreach (vecs[i]) begin
      check($sformatf("model_vec%0d", i), model_res(vecs[i].op, vecs[i].a, vecs[i].b),
            vecs[i].res);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      finish_op(vecs[i].hold);
    end
    check("model_lat_mul", 32'(model_lat(4'd10, 32'd3, 32'd4)), 32'd33);
    check("model_lat_dz", 32'(model_lat(4'd13, 32'd5, 32'd0)), 32'd1);

    // Reset while the iterative engine is running: no result may appear.
    issue(4'd13, 32'd1000, 32'd3);
    repeat (5) tick();
    check("busy_mid_op", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (W + 5) tick();

    for (int unsigned k = 0; k < 400; k++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if (k % 53 == 52) begin
        repeat ($urandom_range(1, 10)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (W + 2) tick();
      end else begin
        finish_op($urandom_range(0, 2));
      end
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
